// File: rtl/fmap_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fmap_capture_pkg
// Description : Shared state encoding and index-width helper for the
//               feature-map capture buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package fmap_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FULL    = 2'd2
    } state_t;

    // Width of an index into n entries; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fmap_ch_ram.sv
`default_nettype none
// ============================================================================
// Module      : fmap_ch_ram
// Description : Single-channel read-first synchronous RAM, one write port
//               and one registered read port. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fmap_ch_ram
    import fmap_capture_pkg::*;
#(
    parameter int DW    = 20,
    parameter int DEPTH = 576,
    parameter int AW    = idx_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // Non-blocking read of the old word gives read-first behaviour on a collision.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= r_mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fmap_capture_buf.sv
`default_nettype none
// ============================================================================
// Module      : fmap_capture_buf
// Description : One-frame feature-map capture buffer with per-channel RAMs,
//               raster write pointer and 1-cycle readback. Optional
//               per-channel running maximum under FMAP_CAPTURE_MAX_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fmap_capture_buf
    import fmap_capture_pkg::*;
#(
    parameter int CO     = 3,
    parameter int O_F_BW = 20,
    parameter int OUT_W  = 24,
    parameter int OUT_H  = 24
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_arm,
    input  logic                           i_valid,
    input  logic [CO*O_F_BW-1:0]           i_fmap,
    input  logic                           i_rd_en,
    input  logic [idx_w(CO)-1:0]           i_rd_ch,
    input  logic [idx_w(OUT_W*OUT_H)-1:0]  i_rd_addr,
    output logic                           o_rd_valid,
    output logic [O_F_BW-1:0]              o_rd_data,
    output logic                           o_busy,
    output logic                           o_frame_done,
    output logic                           o_overflow,
    output logic [idx_w(OUT_W)-1:0]        o_x,
    output logic [idx_w(OUT_H)-1:0]        o_y,
    output logic [CO*O_F_BW-1:0]           o_ch_max
);

    localparam int DEPTH = OUT_W * OUT_H;
    localparam int CHW   = idx_w(CO);
    localparam int CHW1  = CHW + 1;
    localparam int AW    = idx_w(DEPTH);
    localparam int AW1   = AW + 1;
    localparam int XW    = idx_w(OUT_W);
    localparam int YW    = idx_w(OUT_H);

    localparam logic [XW-1:0]   c_x_last   = XW'(OUT_W - 1);
    localparam logic [YW-1:0]   c_y_last   = YW'(OUT_H - 1);
    localparam logic [CHW1-1:0] c_ch_lim   = CHW1'(CO);
    localparam logic [AW1-1:0]  c_addr_lim = AW1'(DEPTH);

    state_t         r_state, w_state_nxt;
    logic [XW-1:0]  r_x;
    logic [YW-1:0]  r_y;
    logic [AW-1:0]  r_waddr;
    logic           r_frame_done, r_overflow;
    logic           w_accept, w_stray, w_last;

    logic           r_rd_valid, r_rd_oor;
    logic [CHW-1:0] r_rd_ch;
    logic           w_rd_oor;
    logic [AW-1:0]  w_raddr;
    logic [O_F_BW-1:0] w_q [CO];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A sample coinciding with i_arm is dropped in every state.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_stray     = 1'b0;
        w_last      = (r_x == c_x_last) && (r_y == c_y_last);
        case (r_state)
            CAPTURE: begin
                w_accept = i_valid && !i_arm;
                if (w_accept && w_last) begin
                    w_state_nxt = FULL;
                end
            end
            default: begin
                w_stray = i_valid && !i_arm;
                if (i_arm) begin
                    w_state_nxt = CAPTURE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x          <= '0;
            r_y          <= '0;
            r_waddr      <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= w_accept && w_last;
            if (i_arm) begin
                r_x        <= '0;
                r_y        <= '0;
                r_waddr    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_stray) begin
                    r_overflow <= 1'b1;
                end
                if (w_accept) begin
                    if (w_last) begin
                        r_x     <= '0;
                        r_y     <= '0;
                        r_waddr <= '0;
                    end else if (r_x == c_x_last) begin
                        r_x     <= '0;
                        r_y     <= r_y + 1'b1;
                        r_waddr <= r_waddr + 1'b1;
                    end else begin
                        r_x     <= r_x + 1'b1;
                        r_waddr <= r_waddr + 1'b1;
                    end
                end
            end
        end
    end

    // Out-of-range requests are steered to entry 0 and masked to zero on output.
    assign w_rd_oor = ({1'b0, i_rd_ch} >= c_ch_lim) || ({1'b0, i_rd_addr} >= c_addr_lim);
    assign w_raddr  = w_rd_oor ? '0 : i_rd_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_oor   <= 1'b0;
            r_rd_ch    <= '0;
        end else begin
            r_rd_valid <= i_rd_en;
            r_rd_oor   <= w_rd_oor;
            r_rd_ch    <= w_rd_oor ? '0 : i_rd_ch;
        end
    end

    generate
        for (genvar c = 0; c < CO; c++) begin : g_ch
            fmap_ch_ram #(
                .DW    (O_F_BW),
                .DEPTH (DEPTH),
                .AW    (AW)
            ) u_ram (
                .clk   (clk),
                .we    (w_accept),
                .waddr (r_waddr),
                .wdata (i_fmap[c*O_F_BW +: O_F_BW]),
                .re    (i_rd_en),
                .raddr (w_raddr),
                .rdata (w_q[c])
            );
        end
    endgenerate

`ifdef FMAP_CAPTURE_MAX_EN
    generate
        for (genvar c = 0; c < CO; c++) begin : g_max
            logic [O_F_BW-1:0] r_max;
            always_ff @(posedge clk) begin
                if (reset || i_arm) begin
                    r_max <= '0;
                end else if (w_accept && (i_fmap[c*O_F_BW +: O_F_BW] > r_max)) begin
                    r_max <= i_fmap[c*O_F_BW +: O_F_BW];
                end
            end
            assign o_ch_max[c*O_F_BW +: O_F_BW] = r_max;
        end
    endgenerate
`else
    assign o_ch_max = '0;
`endif

    assign o_rd_valid   = r_rd_valid;
    assign o_rd_data    = (r_rd_valid && !r_rd_oor) ? w_q[r_rd_ch] : '0;
    assign o_busy       = (r_state == CAPTURE);
    assign o_frame_done = r_frame_done;
    assign o_overflow   = r_overflow;
    assign o_x          = r_x;
    assign o_y          = r_y;

endmodule
`default_nettype wire

// File: tb/tb_fmap_capture_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_fmap_capture_buf
// Description : Directed self-checking bench for fmap_capture_buf (default
//               parameters; o_ch_max expectations follow FMAP_CAPTURE_MAX_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fmap_capture_buf;

`ifdef FMAP_CAPTURE_MAX_EN
    localparam bit MAX_EN = 1'b1;
`else
    localparam bit MAX_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_arm = 1'b0;
    logic        i_valid = 1'b0;
    logic [59:0] i_fmap = '0;
    logic        i_rd_en = 1'b0;
    logic [1:0]  i_rd_ch = '0;
    logic [9:0]  i_rd_addr = '0;
    logic        o_rd_valid;
    logic [19:0] o_rd_data;
    logic        o_busy, o_frame_done, o_overflow;
    logic [4:0]  o_x, o_y;
    logic [59:0] o_ch_max;

    int n_vec = 0;
    int n_err = 0;

    fmap_capture_buf #(
        .CO(3), .O_F_BW(20), .OUT_W(24), .OUT_H(24)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_arm        (i_arm),
        .i_valid      (i_valid),
        .i_fmap       (i_fmap),
        .i_rd_en      (i_rd_en),
        .i_rd_ch      (i_rd_ch),
        .i_rd_addr    (i_rd_addr),
        .o_rd_valid   (o_rd_valid),
        .o_rd_data    (o_rd_data),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_overflow   (o_overflow),
        .o_x          (o_x),
        .o_y          (o_y),
        .o_ch_max     (o_ch_max)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  ch;
        logic [9:0]  addr;
        logic [19:0] exp;
    } rd_vec_t;

    rd_vec_t rd_tab[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [59:0] pack(input int base, input int i);
        logic [59:0] v;
        int s;
        v = '0;
        for (int c = 0; c < 3; c++) begin
            s = base + c * 1000 + i;
            v[c*20 +: 20] = s[19:0];
        end
        return v;
    endfunction

    task automatic arm();
        i_arm = 1'b1;
        step();
        i_arm = 1'b0;
    endtask

    task automatic feed(input int n, input int base, input int gap,
                        output int pulses, output int first_at);
        pulses   = 0;
        first_at = -1;
        for (int i = 0; i < n; i++) begin
            i_fmap  = pack(base, i);
            i_valid = 1'b1;
            step();
            i_valid = 1'b0;
            if (o_frame_done) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
            for (int g = 0; g < gap; g++) begin
                step();
                if (o_frame_done) pulses++;
            end
        end
    endtask

    task automatic read_chk(input string name, input logic [1:0] ch,
                            input logic [9:0] addr, input logic [19:0] exp);
        i_rd_en   = 1'b1;
        i_rd_ch   = ch;
        i_rd_addr = addr;
        step();
        i_rd_en = 1'b0;
        check({name, " valid"}, 64'(o_rd_valid), 64'd1);
        check({name, " data"}, 64'(o_rd_data), 64'(exp));
    endtask

    int pulses, first_at;
    logic [59:0] exp_max;

    initial begin
        rd_tab[0] = '{2'd0, 10'd0,    20'd0};
        rd_tab[1] = '{2'd1, 10'd0,    20'd1000};
        rd_tab[2] = '{2'd2, 10'd575,  20'd2575};
        rd_tab[3] = '{2'd2, 10'd100,  20'd2100};
        rd_tab[4] = '{2'd0, 10'd575,  20'd575};
        rd_tab[5] = '{2'd1, 10'd300,  20'd1300};
        rd_tab[6] = '{2'd3, 10'd0,    20'd0};
        rd_tab[7] = '{2'd1, 10'd576,  20'd0};
        rd_tab[8] = '{2'd2, 10'd1023, 20'd0};

        // Reset state
        step();
        step();
        reset = 1'b0;
        check("rst busy", 64'(o_busy), 64'd0);
        check("rst x", 64'(o_x), 64'd0);
        check("rst y", 64'(o_y), 64'd0);
        check("rst frame_done", 64'(o_frame_done), 64'd0);
        check("rst overflow", 64'(o_overflow), 64'd0);
        check("rst rd_valid", 64'(o_rd_valid), 64'd0);
        check("rst rd_data", 64'(o_rd_data), 64'd0);
        check("rst ch_max", 64'(o_ch_max), 64'd0);

        // Full frame
        arm();
        check("arm busy", 64'(o_busy), 64'd1);
        feed(576, 0, 0, pulses, first_at);
        check("frame pulses", 64'(pulses), 64'd1);
        check("frame pulse idx", 64'(first_at), 64'd575);
        check("full busy", 64'(o_busy), 64'd0);
        check("full x wrap", 64'(o_x), 64'd0);
        check("full y wrap", 64'(o_y), 64'd0);
        exp_max = MAX_EN ? {20'd2575, 20'd1575, 20'd575} : 60'd0;
        check("frame ch_max", 64'(o_ch_max), 64'(exp_max));
        step();
        check("frame_done single", 64'(o_frame_done), 64'd0);
        check("full hold max", 64'(o_ch_max), 64'(exp_max));

        // Readback table, including out-of-range channel/address
        for (int k = 0; k < 9; k++) begin
            read_chk($sformatf("rd[%0d]", k), rd_tab[k].ch, rd_tab[k].addr, rd_tab[k].exp);
        end
        step();
        check("rd_valid drop", 64'(o_rd_valid), 64'd0);

        // Stray sample in FULL
        i_fmap  = {3{20'h12345}};
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        check("ovf set", 64'(o_overflow), 64'd1);
        check("ovf busy", 64'(o_busy), 64'd0);
        step();
        check("ovf sticky", 64'(o_overflow), 64'd1);
        read_chk("ovf mem0", 2'd1, 10'd0, 20'd1000);
        arm();
        check("rearm ovf clr", 64'(o_overflow), 64'd0);
        check("rearm busy", 64'(o_busy), 64'd1);

        // Read-first on a same-cycle write to addr 0
        i_fmap    = {20'd7, 20'd7777, 20'd7};
        i_valid   = 1'b1;
        i_rd_en   = 1'b1;
        i_rd_ch   = 2'd1;
        i_rd_addr = 10'd0;
        step();
        i_valid = 1'b0;
        i_rd_en = 1'b0;
        check("rf old data", 64'(o_rd_data), 64'd1000);
        check("rf x adv", 64'(o_x), 64'd1);
        read_chk("rf new data", 2'd1, 10'd0, 20'd7777);

        // Arm with a coincident valid: sample dropped, no overflow
        i_arm   = 1'b1;
        i_valid = 1'b1;
        step();
        i_arm   = 1'b0;
        i_valid = 1'b0;
        check("arm+valid x", 64'(o_x), 64'd0);
        check("arm+valid ovf", 64'(o_overflow), 64'd0);
        check("arm+valid busy", 64'(o_busy), 64'd1);

        // Gapped samples: position moves only on valid
        for (int i = 0; i < 24; i++) begin
            i_fmap  = pack(0, i);
            i_valid = 1'b1;
            step();
            i_valid = 1'b0;
            check($sformatf("gap x[%0d]", i), 64'(o_x), 64'((i + 1) % 24));
            check($sformatf("gap y[%0d]", i), 64'(o_y), 64'((i + 1) / 24));
            for (int g = 0; g < (i % 3) + 1; g++) step();
            check($sformatf("gap hold x[%0d]", i), 64'(o_x), 64'((i + 1) % 24));
        end

        // Restart after 100 samples
        arm();
        feed(100, 0, 0, pulses, first_at);
        check("pre-restart x", 64'(o_x), 64'd4);
        check("pre-restart y", 64'(o_y), 64'd4);
        arm();
        check("restart x", 64'(o_x), 64'd0);
        check("restart y", 64'(o_y), 64'd0);
        check("restart busy", 64'(o_busy), 64'd1);
        feed(576, 0, 0, pulses, first_at);
        check("restart pulses", 64'(pulses), 64'd1);
        check("restart pulse idx", 64'(first_at), 64'd575);

        // Reset in the middle of a frame
        arm();
        feed(300, 40000, 0, pulses, first_at);
        reset   = 1'b1;
        i_valid = 1'b1;
        i_rd_en = 1'b1;
        step();
        reset   = 1'b0;
        i_valid = 1'b0;
        i_rd_en = 1'b0;
        check("mid-rst busy", 64'(o_busy), 64'd0);
        check("mid-rst x", 64'(o_x), 64'd0);
        check("mid-rst y", 64'(o_y), 64'd0);
        check("mid-rst rd_valid", 64'(o_rd_valid), 64'd0);
        check("mid-rst rd_data", 64'(o_rd_data), 64'd0);
        check("mid-rst ch_max", 64'(o_ch_max), 64'd0);
        check("mid-rst overflow", 64'(o_overflow), 64'd0);
        if (o_frame_done) pulses++;
        step();
        if (o_frame_done) pulses++;
        check("mid-rst no done", 64'(pulses), 64'd0);
        read_chk("mid-rst mem ch0", 2'd0, 10'd10, 20'd40010);
        read_chk("mid-rst mem ch2", 2'd2, 10'd10, 20'd42010);

        // Running maximum with a full-scale peak at sample 7
        arm();
        for (int i = 0; i < 10; i++) begin
            i_fmap[19:0]  = (i == 7) ? 20'hFFFFF : 20'(i);
            i_fmap[39:20] = 20'(3 * i);
            i_fmap[59:40] = 20'(100 - i);
            i_valid = 1'b1;
            step();
            i_valid = 1'b0;
            if (i == 7) begin
                check("max ch0 peak", 64'(o_ch_max[19:0]), MAX_EN ? 64'hFFFFF : 64'd0);
            end
        end
        exp_max = MAX_EN ? {20'd100, 20'd27, 20'hFFFFF} : 60'd0;
        check("max final", 64'(o_ch_max), 64'(exp_max));
        arm();
        check("max clr on arm", 64'(o_ch_max), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fmap_capture_buf.md
FMAP_CAPTURE_BUF -- requirements
Module: fmap_capture_buf

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- CO, 3, feature-map channel count.
- O_F_BW, 20, bits per channel sample.
- OUT_W, 24, frame width in samples.
- OUT_H, 24, frame height in rows.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, all logic on rising edge.
- reset, in, 1, synchronous, active-high.
- i_arm, in, 1, start or restart a one-frame capture.
- i_valid, in, 1, input sample strobe.
- i_fmap, in, CO*O_F_BW, channel c occupies bits [c*O_F_BW +: O_F_BW].
- i_rd_en, in, 1, readback request.
- i_rd_ch, in, clog2(CO), readback channel.
- i_rd_addr, in, clog2(OUT_W*OUT_H), readback address, equal to y*OUT_W+x.
- o_rd_valid, out, 1, readback data valid.
- o_rd_data, out, O_F_BW, readback sample.
- o_busy, out, 1, high while in CAPTURE.
- o_frame_done, out, 1, one-cycle pulse when the last sample is written.
- o_overflow, out, 1, sticky, set when a sample arrives while not capturing.
- o_x, out, clog2(OUT_W), current write column.
- o_y, out, clog2(OUT_H), current write row.
- o_ch_max, out, CO*O_F_BW, per-channel unsigned maximum (see Configuration).

Function
REQ-003 The state machine SHALL have three states: IDLE, CAPTURE and FULL.
REQ-004 On i_arm in IDLE or FULL, the block SHALL enter CAPTURE on the next cycle, clear x and y to 0, and clear o_overflow.
REQ-005 On i_arm in CAPTURE, the block SHALL restart: x and y return to 0 and the state stays CAPTURE.
REQ-006 An i_valid in the same cycle as i_arm SHALL be discarded and SHALL NOT set o_overflow.
REQ-007 In CAPTURE with i_valid, the block SHALL write all CO channels of i_fmap at address y*OUT_W+x.
REQ-008 x SHALL increment on each accepted sample; at x=OUT_W-1, x SHALL wrap to 0 and y SHALL increment.
REQ-009 The sample written at x=OUT_W-1, y=OUT_H-1 SHALL cause o_frame_done to pulse high for exactly one cycle, and the state SHALL become FULL on the next cycle.
REQ-010 After that last sample, x and y SHALL wrap to 0.
REQ-011 i_valid in IDLE or FULL SHALL NOT write memory and SHALL set o_overflow, which stays set until i_arm or reset.
REQ-012 Readback latency SHALL be 1 cycle: o_rd_valid is i_rd_en delayed by one cycle, and o_rd_data is the stored sample.
REQ-013 Readback SHALL be allowed in any state.
REQ-014 A simultaneous read and write to the same address SHALL return the old data (read-first).
REQ-015 Out-of-range i_rd_ch or i_rd_addr SHALL return 0 with o_rd_valid still asserted.
REQ-016 o_busy SHALL equal (state==CAPTURE).
REQ-017 o_x and o_y SHALL show the next write position.

Reset
REQ-018 When reset is high at a clock edge, the block SHALL take these values on that edge: state IDLE, x=0, y=0, o_frame_done=0, o_overflow=0, o_rd_valid=0, o_rd_data=0, o_ch_max=0.
REQ-019 Memory contents SHALL NOT be cleared by reset.
REQ-020 Reset during CAPTURE SHALL abandon the frame and SHALL NOT generate o_frame_done.

Configuration
REQ-021 With FMAP_CAPTURE_MAX_EN defined, o_ch_max SHALL track the unsigned maximum of each channel over all accepted samples in the current capture.
REQ-022 With FMAP_CAPTURE_MAX_EN defined, o_ch_max SHALL clear on i_arm and hold its value in FULL.
REQ-023 Without FMAP_CAPTURE_MAX_EN, o_ch_max SHALL be constant 0 and no comparator logic SHALL be built.

Structure
REQ-024 Package fmap_capture_pkg SHALL hold the state enum (IDLE, CAPTURE, FULL) and the address-width localparam helper functions.
REQ-025 There SHALL be one sub-module, fmap_ch_ram: a single-channel, O_F_BW-wide, OUT_W*OUT_H-deep, read-first synchronous RAM, instantiated CO times.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Arm, then 576 consecutive valids with channel c value = c*1000+index: o_frame_done pulses once, on the cycle of sample 575; the state is FULL; reading ch2 addr 575 gives 2575.
- Valids with gaps of 1-3 idle cycles: x and y advance only on valid; at sample 24, o_x=0 and o_y=1.
- In FULL, one valid: o_overflow=1 and memory unchanged; then i_arm: o_overflow=0 and o_busy=1.
- i_arm after sample 100 of a frame: o_x=0, o_y=0, and o_frame_done occurs only after 576 further samples.
- Reset asserted at sample 300: all outputs return to reset values, no o_frame_done pulse, and a read of addr 10 still returns the pre-reset data.
- With FMAP_CAPTURE_MAX_EN, ch0 peak 0xFFFFF at sample 7: o_ch_max[ch0]=0xFFFFF; without the macro, o_ch_max=0 throughout.
